// File: rtl/nonrestoring_divider.sv
// Signed WIDTH-bit divider built on a non-restoring shift/add-sub loop.
// Operands are reduced to unsigned magnitudes. One quotient bit is produced
// per clock. The signs are applied in FIX. Division by zero bypasses the loop
// through ZERO and produces quotient = all ones and remainder = dividend.
module nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_ZRO = CW'(0);
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZRO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   PREM_ZRO = {(WIDTH+1){1'b0}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3,
        ZERO = 3'd4
    } state_t;

    // Two's-complement negation helper
    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a signed value; the most-negative value maps to 2^(WIDTH-1)
    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_f(v) : v;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] dividend_r, divisor_r, dmag_r, quo_r;
    logic [WIDTH:0]   prem_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             dbz_r, ovf_r, busy_r, done_r;

    logic [WIDTH:0]   shift_s, iter_s, rest_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;
    logic             ovf_s;

    // Next-state logic for the five-state controller
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (divisor == ALL_ZRO) ? ZERO : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ZRO) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:  state_s = DONE;
            ZERO: begin
                if (cnt_r == CNT_ZRO) begin
                    state_s = DONE;
                end else begin
                    state_s = ZERO;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One non-restoring step, the final restore and the sign correction
    always_comb begin
        shift_s = {prem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        if (prem_r[WIDTH] == 1'b0) begin
            iter_s = shift_s - {1'b0, dmag_r};
        end else begin
            iter_s = shift_s + {1'b0, dmag_r};
        end
        if (prem_r[WIDTH] == 1'b1) begin
            rest_s = prem_r + {1'b0, dmag_r};
        end else begin
            rest_s = prem_r;
        end
        if ((dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]) == 1'b1) begin
            quo_fix_s = neg_f(quo_r);
        end else begin
            quo_fix_s = quo_r;
        end
        if (dividend_r[WIDTH-1] == 1'b1) begin
            rem_fix_s = neg_f(rest_s[WIDTH-1:0]);
        end else begin
            rem_fix_s = rest_s[WIDTH-1:0];
        end
        ovf_s = (dividend_r == MIN_VAL) && (divisor_r == ALL_ONE);
    end

    // State register plus registered busy/done derived from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dividend_r  <= ALL_ZRO;
            divisor_r   <= ALL_ZRO;
            dmag_r      <= ALL_ZRO;
            quo_r       <= ALL_ZRO;
            prem_r      <= PREM_ZRO;
            cnt_r       <= CNT_ZRO;
            quotient_r  <= ALL_ZRO;
            remainder_r <= ALL_ZRO;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        dmag_r     <= abs_f(divisor);
                        quo_r      <= abs_f(dividend);
                        prem_r     <= PREM_ZRO;
                        // ZERO spends two edges so done lands two edges after start
                        cnt_r      <= (divisor == ALL_ZRO) ? CNT_ONE : CNT_MAX;
                        dbz_r      <= 1'b0;
                        ovf_r      <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                CALC: begin
                    prem_r <= iter_s;
                    quo_r  <= {quo_r[WIDTH-2:0], ~iter_s[WIDTH]};
                    if (cnt_r != CNT_ZRO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        cnt_r <= CNT_ZRO;
                    end
                end
                FIX: begin
                    quotient_r  <= quo_fix_s;
                    remainder_r <= rem_fix_s;
                    ovf_r       <= ovf_s;
                end
                ZERO: begin
                    quotient_r  <= ALL_ONE;
                    remainder_r <= dividend_r;
                    dbz_r       <= 1'b1;
                    if (cnt_r != CNT_ZRO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        cnt_r <= CNT_ZRO;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= CNT_ZRO;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider (WIDTH=8). Expected results are
// queued when an operation is issued and popped when done is seen.
module tb_nonrestoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } res_t;

    res_t sb_q[$];

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Truncating signed reference built on integer arithmetic
    function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t e;
        int   ia;
        int   ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1; e.ovf = 1'b0;
        end else if (ia == -128 && ib == -1) begin
            e.q = 8'h80; e.r = 8'h00; e.dbz = 1'b0; e.ovf = 1'b1;
        end else begin
            e.q = 8'(ia / ib); e.r = 8'(ia % ib); e.dbz = 1'b0; e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Pulse start for one edge, then count edges until done (bounded)
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit rel, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        if (rel) reset = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (quotient !== 8'h00) begin errors++; $display("FAIL rst_q got %h exp 00", quotient); end
        checks++; if (remainder !== 8'h00) begin errors++; $display("FAIL rst_r got %h exp 00", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_dbz got %b exp 0", div_by_zero); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy got %b exp 0", busy); end
        reset = 1'b1;
    endtask

    task automatic test_signed();
        logic [W-1:0] ta [9] = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'h7F, 8'h00, 8'h03, 8'h05};
        logic [W-1:0] tb [9] = '{8'd7,   8'd7,  8'hF9,  8'hF9, 8'hFF, 8'hFF, 8'h05, 8'h80, 8'h00};
        logic [W-1:0] tq [9] = '{8'h0E,  8'hF2, 8'hF2,  8'h0E, 8'h80, 8'h81, 8'h00, 8'h00, 8'hFF};
        logic [W-1:0] tr [9] = '{8'h02,  8'hFE, 8'h02,  8'hFE, 8'h00, 8'h00, 8'h00, 8'h03, 8'h05};
        logic         tz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         tv [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int           tl [9] = '{9, 9, 9, 9, 9, 9, 9, 9, 2};
        res_t e;
        int   lat;
        for (int i = 0; i < 9; i++) begin
            sb_q.push_back('{tq[i], tr[i], tz[i], tv[i]});
            issue(ta[i], tb[i], 1'b0, lat);
            e = sb_q.pop_front();
            checks++; if (lat !== tl[i]) begin errors++; $display("FAIL sgn_lat idx=%0d got %0d exp %0d", i, lat, tl[i]); end
            checks++; if (quotient !== e.q) begin errors++; $display("FAIL sgn_q idx=%0d got %h exp %h", i, quotient, e.q); end
            checks++; if (remainder !== e.r) begin errors++; $display("FAIL sgn_r idx=%0d got %h exp %h", i, remainder, e.r); end
            checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL sgn_dbz idx=%0d got %b exp %b", i, div_by_zero, e.dbz); end
            checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL sgn_ovf idx=%0d got %b exp %b", i, overflow, e.ovf); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sgn_busy_in_done idx=%0d got %b exp 1", i, busy); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sgn_after idx=%0d done %b busy %b exp 0 0", i, done, busy); end
            checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL sgn_hold idx=%0d got %h/%h exp %h/%h", i, quotient, remainder, e.q, e.r); end
        end
    endtask

    task automatic test_reset_mid_op();
        res_t e;
        int   lat;
        int   ndone;
        @(negedge clk);
        start = 1'b1; dividend = 8'd77; divisor = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl busy %b done %b exp 0 0", busy, done); end
        checks++; if (quotient !== 8'h00 || remainder !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h/%h exp 00/00", quotient, remainder); end
        checks++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got %b%b exp 00", div_by_zero, overflow); end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL mid_rst_nodone got %0d exp 0", ndone); end
        sb_q.push_back('{8'd15, 8'd2, 1'b0, 1'b0});
        issue(8'd77, 8'd5, 1'b1, lat);
        e = sb_q.pop_front();
        checks++; if (lat !== 9) begin errors++; $display("FAIL post_rst_lat got %0d exp 9", lat); end
        checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL post_rst_res got %h/%h exp %h/%h", quotient, remainder, e.q, e.r); end
    endtask

    task automatic test_start_while_busy();
        res_t         e;
        int           ndone;
        int           first;
        logic [W-1:0] gq, gr;
        gq = '0; gr = '0;
        sb_q.push_back('{8'd16, 8'd2, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) begin first = i; gq = quotient; gr = remainder; end
            end
            start = (i == 2);
            dividend = (i == 2) ? 8'd9 : 8'($urandom);
            divisor  = (i == 2) ? 8'd2 : 8'($urandom);
        end
        e = sb_q.pop_front();
        checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_ndone got %0d exp 1", ndone); end
        checks++; if (first !== 9) begin errors++; $display("FAIL busy_start_lat got %0d exp 9", first); end
        checks++; if (gq !== e.q || gr !== e.r) begin errors++; $display("FAIL busy_start_res got %h/%h exp %h/%h", gq, gr, e.q, e.r); end
    endtask

    task automatic test_start_in_done();
        res_t e;
        int   lat;
        sb_q.push_back(ref_div(8'd20, 8'd3));
        issue(8'd20, 8'd3, 1'b0, lat);
        e = sb_q.pop_front();
        start = 1'b1; dividend = 8'd7; divisor = 8'd1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_start_busy got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL done_start_hold got %h/%h exp %h/%h", quotient, remainder, e.q, e.r); end
    endtask

    task automatic test_random();
        logic [W-1:0] bv [7] = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h02, 8'hFE};
        logic [W-1:0] a, b;
        res_t         e;
        int           lat;
        for (int n = 0; n < 2549; n++) begin
            if (n < 49) begin
                a = bv[n / 7]; b = bv[n % 7];
            end else begin
                a = ($urandom_range(7) == 0) ? bv[$urandom_range(6)] : 8'($urandom);
                b = ($urandom_range(7) == 0) ? bv[$urandom_range(6)] : 8'($urandom);
            end
            sb_q.push_back(ref_div(a, b));
            issue(a, b, 1'b0, lat);
            e = sb_q.pop_front();
            checks++; if (lat !== (e.dbz ? 2 : 9)) begin errors++; $display("FAIL rnd_lat %h/%h got %0d", a, b, lat); end
            checks++; if (quotient !== e.q) begin errors++; $display("FAIL rnd_q %h/%h got %h exp %h", a, b, quotient, e.q); end
            checks++; if (remainder !== e.r) begin errors++; $display("FAIL rnd_r %h/%h got %h exp %h", a, b, remainder, e.r); end
            checks++; if (div_by_zero !== e.dbz || overflow !== e.ovf) begin errors++; $display("FAIL rnd_flags %h/%h got %b%b exp %b%b", a, b, div_by_zero, overflow, e.dbz, e.ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_reset_mid_op();
        test_start_while_busy();
        test_start_in_done();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
